// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO with selectable read mode, occupancy and
// threshold flags, and sticky error flags.
//
// Parameters
//   DATA_WIDTH  bits per word
//   ADDR_WIDTH  address bits; DEPTH = 2**ADDR_WIDTH words
//   FWFT        0 = registered read (data one cycle after rd),
//               1 = first-word-fall-through (head word always presented)
//
// Ports
//   clk           rising-edge clock for all state
//   reset_n       synchronous active-low reset (overrides clr, rd, wr)
//   clr           synchronous flush (overrides rd, wr)
//   wr, w_data    write request and word
//   rd            read / pop request
//   ae_level      almost-empty threshold (almost_empty = count <= ae_level)
//   af_level      almost-full threshold  (almost_full  = count >= af_level)
//   r_data        read word, qualified by r_valid
//   empty, full   occupancy flags
//   almost_empty, almost_full  threshold flags
//   word_count    occupancy, 0..DEPTH
//   overflow      sticky: write attempted while full with no read
//   underflow     sticky: read attempted while empty
module fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  input  logic [ADDR_WIDTH:0]   ae_level,
  input  logic [ADDR_WIDTH:0]   af_level,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;

  // Flags come straight from the registered count, so they are glitch-free
  // with respect to the request inputs.
  assign empty        = (word_count == '0);
  assign full         = (word_count == FULL_COUNT);
  assign almost_empty = (word_count <= ae_level);
  assign almost_full  = (word_count >= af_level);

  // A write into a full FIFO is still legal when a read frees a slot in the
  // same cycle; a read on an empty FIFO is never accepted, even alongside a
  // write (the new word is not yet readable).
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);

      // Acceptance rules already keep the count inside 0..DEPTH.
      case ({wr_acc, rd_acc})
        2'b10:   word_count <= word_count + (ADDR_WIDTH + 1)'(1);
        2'b01:   word_count <= word_count - (ADDR_WIDTH + 1)'(1);
        default: word_count <= word_count;
      endcase

      if (wr && full && !rd) overflow  <= 1'b1;
      if (rd && empty)       underflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by pointers
  // and count, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (reset_n && !clr && wr_acc) mem[wr_ptr] <= w_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always on the bus; forced to zero while empty so the
      // output is defined (and zero) straight after reset.
      assign r_data  = empty ? '0 : mem[rd_ptr];
      assign r_valid = ~empty;
    end else begin : g_registered
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else if (clr) begin
          r_valid <= 1'b0;
        end else begin
          r_valid <= rd_acc;
          if (rd_acc) r_data <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: drives one registered-read and one FWFT instance of fifo_flex
// (DATA_WIDTH=8, ADDR_WIDTH=2) with identical stimulus. A queue scoreboard
// receives each accepted write and is popped as the design returns data.
module tb_fifo_flex;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset_n;
  logic          clr;
  logic          wr;
  logic          rd;
  logic [DW-1:0] w_data;
  logic [AW:0]   ae_level;
  logic [AW:0]   af_level;

  logic [DW-1:0] r_data0, r_data1;
  logic          r_valid0, r_valid1;
  logic          empty0, empty1, full0, full1;
  logic          ae0, ae1, af0, af1;
  logic [AW:0]   count0, count1;
  logic          ov0, ov1, uf0, uf1;

  fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
    .ae_level(ae_level), .af_level(af_level), .r_data(r_data0), .r_valid(r_valid0),
    .empty(empty0), .full(full0), .almost_empty(ae0), .almost_full(af0),
    .word_count(count0), .overflow(ov0), .underflow(uf0)
  );

  fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
    .ae_level(ae_level), .af_level(af_level), .r_data(r_data1), .r_valid(r_valid1),
    .empty(empty1), .full(full1), .almost_empty(ae1), .almost_full(af1),
    .word_count(count1), .overflow(ov1), .underflow(uf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] q[$];
  logic          m_ov;
  logic          m_uf;
  logic          exp_rv0;
  logic [DW-1:0] last_r0;
  int            max_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances against the scoreboard.
  task automatic check_all();
    check("count0", 32'(count0), q.size());
    check("count1", 32'(count1), q.size());
    check("empty0", 32'(empty0), 32'(q.size() == 0));
    check("empty1", 32'(empty1), 32'(q.size() == 0));
    check("full0", 32'(full0), 32'(q.size() == DEPTH));
    check("ae0", 32'(ae0), 32'(q.size() <= int'(ae_level)));
    check("af0", 32'(af0), 32'(q.size() >= int'(af_level)));
    check("ov0", 32'(ov0), 32'(m_ov));
    check("uf0", 32'(uf0), 32'(m_uf));
    check("rvalid0", 32'(r_valid0), 32'(exp_rv0));
    check("rdata0", 32'(r_data0), 32'(last_r0));
    check("rvalid1", 32'(r_valid1), 32'(q.size() != 0));
    if (q.size() != 0) check("rdata1", 32'(r_data1), 32'(q[0]));
  endtask

  // One clock: drive requests, update the scoreboard from pre-edge state,
  // then sample 1 time unit after the edge.
  task automatic tick(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c, input logic rst = 1'b0);
    logic m_empty, m_full, rd_a, wr_a;
    wr      = w;
    w_data  = d;
    rd      = r;
    clr     = c;
    reset_n = ~rst;
    m_empty = (q.size() == 0);
    m_full  = (q.size() == DEPTH);
    rd_a    = r && !m_empty;
    wr_a    = w && (!m_full || rd_a);
    exp_rv0 = 1'b0;
    if (rst || c) begin
      q.delete();
      m_ov = 1'b0;
      m_uf = 1'b0;
      if (rst) last_r0 = '0;
    end else begin
      if (w && m_full && !r) m_ov = 1'b1;
      if (r && m_empty)      m_uf = 1'b1;
      if (rd_a) begin
        last_r0 = q.pop_front();
        exp_rv0 = 1'b1;
      end
      if (wr_a) q.push_back(d);
    end
    @(posedge clk);
    #1;
    wr      = 1'b0;
    rd      = 1'b0;
    clr     = 1'b0;
    reset_n = 1'b1;
    check_all();
  endtask

  initial begin
    reset_n  = 1'b0;
    clr      = 1'b0;
    wr       = 1'b0;
    rd       = 1'b0;
    w_data   = '0;
    ae_level = 3'd1;
    af_level = 3'd3;
    m_ov     = 1'b0;
    m_uf     = 1'b0;
    exp_rv0  = 1'b0;
    last_r0  = '0;

    // Reset with wr/rd asserted: reset must win.
    tick(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    check("rst_rdata0", 32'(r_data0), 32'h0);
    check("rst_rdata1", 32'(r_data1), 32'h0);
    check("rst_ae", 32'(ae0), 32'h1);
    check("rst_af", 32'(af0), 32'h0);

    // Fill, overflow, drain in order.
    tick(1'b1, 8'h11, 1'b0, 1'b0);
    tick(1'b1, 8'h22, 1'b0, 1'b0);
    tick(1'b1, 8'h33, 1'b0, 1'b0);
    tick(1'b1, 8'h44, 1'b0, 1'b0);
    check("fill_full", 32'(full0), 32'h1);
    check("fill_count", 32'(count0), 32'h4);
    check("fill_af", 32'(af0), 32'h1);
    tick(1'b1, 8'h55, 1'b0, 1'b0);
    check("ovf_flag", 32'(ov0), 32'h1);
    check("ovf_count", 32'(count0), 32'h4);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_1", 32'(r_data0), 32'h11);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_4", 32'(r_data0), 32'h44);
    check("drain_empty", 32'(empty0), 32'h1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("idle_rvalid", 32'(r_valid0), 32'h0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", 32'(ov0), 32'h0);

    // Underflow, then clear it.
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_flag", 32'(uf0), 32'h1);
    check("udf_rvalid", 32'(r_valid0), 32'h0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_udf", 32'(uf0), 32'h0);

    // rd+wr on empty: only the write lands, underflow sets.
    tick(1'b1, 8'h3C, 1'b1, 1'b0);
    check("rw_empty_count", 32'(count0), 32'h1);
    check("rw_empty_udf", 32'(uf0), 32'h1);
    // Flush with requests asserted while non-empty: clr wins.
    tick(1'b1, 8'h99, 1'b1, 1'b1);
    check("clr_wins", 32'(count0), 32'h0);

    // Full FIFO with simultaneous rd+wr.
    tick(1'b1, 8'h01, 1'b0, 1'b0);
    tick(1'b1, 8'h02, 1'b0, 1'b0);
    tick(1'b1, 8'h03, 1'b0, 1'b0);
    tick(1'b1, 8'h04, 1'b0, 1'b0);
    tick(1'b1, 8'hAA, 1'b1, 1'b0);
    check("full_rw_count", 32'(count0), 32'h4);
    check("full_rw_ovf", 32'(ov0), 32'h0);
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("full_rw_last", 32'(r_data0), 32'hAA);

    // FWFT: word written into empty appears without rd.
    tick(1'b1, 8'h5A, 1'b0, 1'b0);
    check("fwft_data", 32'(r_data1), 32'h5A);
    check("fwft_valid", 32'(r_valid1), 32'h1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_pop_empty", 32'(empty1), 32'h1);
    check("fwft_pop_valid", 32'(r_valid1), 32'h0);

    // Ten words through the pointer wrap, occupancy never above one.
    max_count = 0;
    tick(1'b1, 8'h00, 1'b0, 1'b0);
    if (int'(count0) > max_count) max_count = int'(count0);
    for (int i = 1; i < 10; i++) begin
      tick(1'b1, 8'(i), 1'b1, 1'b0);
      if (int'(count0) > max_count) max_count = int'(count0);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_last", 32'(r_data0), 32'h09);
    check("wrap_max_count", 32'(max_count), 32'h1);

    // Reset mid-operation discards queued words.
    tick(1'b1, 8'hC1, 1'b0, 1'b0);
    tick(1'b1, 8'hC2, 1'b0, 1'b0);
    tick(1'b1, 8'hC3, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("mid_rst_count", 32'(count0), 32'h0);
    check("mid_rst_empty", 32'(empty0), 32'h1);
    check("mid_rst_rvalid", 32'(r_valid0), 32'h0);
    tick(1'b1, 8'h77, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_read", 32'(r_data0), 32'h77);
    check("post_rst_empty", 32'(empty0), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set bits per word.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set address bits; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter FWFT, default 0, SHALL select read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  SHALL be the synchronous, active-low reset.
REQ-006 clr  input  1  SHALL be a synchronous flush request.
REQ-007 wr  input  1  SHALL be the write request.
REQ-008 w_data  input  DATA_WIDTH  SHALL be the write word.
REQ-009 rd  input  1  SHALL be the read/pop request.
REQ-010 ae_level  input  ADDR_WIDTH+1  SHALL be the almost-empty threshold.
REQ-011 af_level  input  ADDR_WIDTH+1  SHALL be the almost-full threshold.
REQ-012 r_data  output  DATA_WIDTH  SHALL be the read word.
REQ-013 r_valid  output  1  SHALL qualify r_data.
REQ-014 empty, full  output  1 each  SHALL be occupancy flags.
REQ-015 almost_empty, almost_full  output  1 each  SHALL be threshold flags.
REQ-016 word_count  output  ADDR_WIDTH+1  SHALL be current occupancy, 0..DEPTH.
REQ-017 overflow, underflow  output  1 each  SHALL be sticky error flags.

Function
REQ-018 Write SHALL be accepted when wr=1 and (full=0 or rd accepted in the same cycle); accepted write stores w_data at write pointer and advances pointer modulo DEPTH.
REQ-019 Read SHALL be accepted when rd=1 and empty=0; accepted read advances read pointer modulo DEPTH.
REQ-020 rd=1 and wr=1 with full=1 SHALL accept both; word_count unchanged.
REQ-021 rd=1 and wr=1 with empty=1 SHALL accept only the write; word_count becomes 1; underflow sets.
REQ-022 word_count SHALL increment on write-only, decrement on read-only, hold otherwise; it SHALL never exceed DEPTH nor go below 0.
REQ-023 empty SHALL equal (word_count==0); full SHALL equal (word_count==DEPTH); both derived from registered state.
REQ-024 almost_empty SHALL equal (word_count <= ae_level); almost_full SHALL equal (word_count >= af_level); comparisons unsigned, combinational from registered count.
REQ-025 FWFT=0: accepted read SHALL present the head word on r_data with r_valid=1 in the next cycle; r_valid=0 in cycles following no accepted read; r_data holds last value otherwise.
REQ-026 FWFT=1: r_data SHALL show the head word and r_valid SHALL equal ~empty, zero latency; rd pops the head.
REQ-027 FWFT=1: a word written into an empty FIFO SHALL appear on r_data with r_valid=1 one cycle after the write.
REQ-028 overflow SHALL set when wr=1, full=1, rd=0; underflow SHALL set when rd=1, empty=1; both hold until clr or reset.
REQ-029 Rejected writes SHALL not alter storage, pointers or count.
REQ-030 clr=1 SHALL, next cycle, zero pointers, word_count, r_valid, overflow, underflow; clr SHALL override rd/wr in that cycle; storage contents need not clear.
REQ-031 Pointer wrap SHALL be seamless: DEPTH+N consecutive write/read pairs return data in order.

Reset
REQ-032 reset_n=0 sampled on clk edge SHALL set pointers=0, word_count=0, empty=1, full=0, r_valid=0, r_data=0, overflow=0, underflow=0; reset overrides clr, rd, wr.
REQ-033 almost_empty/almost_full after reset SHALL follow REQ-024 with word_count=0.
REQ-034 Reset asserted mid-operation SHALL discard all queued words; first read after release sees only post-reset writes.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, ae_level=1, af_level=3)
REQ-035 FWFT=0: write 0x11,0x22,0x33,0x44 -> full=1, word_count=4, almost_full=1; 5th write 0x55 -> overflow=1, count stays 4; four reads -> r_data 0x11,0x22,0x33,0x44 each one cycle after rd, empty=1.
REQ-036 rd on empty FIFO -> underflow=1, r_valid=0, count 0; then clr -> underflow=0.
REQ-037 Full FIFO, rd=1 and wr=1 with 0xAA -> count stays 4, overflow stays 0, 0xAA read out fourth in order.
REQ-038 FWFT=1: write 0x5A into empty -> next cycle r_data=0x5A, r_valid=1 without rd; rd pops -> empty=1, r_valid=0.
REQ-039 Ten write/read pairs 0x00..0x09 across pointer wrap -> output sequence 0x00..0x09 exact, count never exceeds 1.
REQ-040 Load 3 words, assert reset_n=0 one cycle -> count=0, empty=1, flags cleared; write 0x77, read -> 0x77.
